// File: rtl/mult_share_if.sv
// mult_share_if: request/response bundle between the multiply-issuing
// clients and the shared multiplier arbiter.
//
//   req_valid [NREQ]       per-requester request valid
//   req_a     [NREQ*WIDTH] operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b     [NREQ*WIDTH] operand B, packed like req_a
//   req_ready [NREQ]       per-requester accept (one-hot or zero)
//   rsp_valid              result valid
//   rsp_ready              result consumer ready
//   rsp_id    [IDW]        requester index of the result
//   rsp_prod  [2*WIDTH]    unsigned product A*B
//   ops_done  [16]         completed results, wrapping
//
// master: the client side; slave: the arbiter side.
interface mult_share_if #(
  parameter int WIDTH = 25,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic [15:0]           ops_done;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod, ops_done
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter sharing one combinational unsigned
// array multiplier between NREQ requesters.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_share_if.slave (request handshakes, result channel, ops_done)
//
// Pipeline: S1 holds the granted operand pair and ID, the multiplier sits
// between S1 and S2, S2 is the registered result channel.

// Unsigned array multiplier: sum of shifted partial products, one row per
// bit of x.
module array_multiplier #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   x,
  output logic [2*WIDTH-1:0] p
);
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] acc;

  assign a_ext = {{WIDTH{1'b0}}, a};

  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        acc = acc + (a_ext << i);
      end
    end
  end

  assign p = acc;
endmodule

module mult_share_arbiter #(
  parameter int WIDTH = 25,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_share_if.slave bus
);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  // S1
  logic               s1_valid_q, s1_valid_d;
  logic [IDW-1:0]     s1_id_q,    s1_id_d;
  logic [WIDTH-1:0]   s1_a_q,     s1_a_d;
  logic [WIDTH-1:0]   s1_b_q,     s1_b_d;
  // S2
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
  logic [2*WIDTH-1:0] rsp_prod_q,  rsp_prod_d;
  // arbitration / statistics
  logic [IDW-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [15:0]        ops_done_q, ops_done_d;

  logic               s2_load;
  logic               s1_adv;
  logic               can_accept;
  logic               xfer;

  logic [2*NREQ-1:0]  rv_dbl;
  logic [NREQ-1:0]    rv_rot;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_off;
  logic [IDW:0]       gnt_sum;
  logic [IDW-1:0]     gnt_id;
  logic [NREQ-1:0]    grant_oh;
  logic [WIDTH-1:0]   gnt_a;
  logic [WIDTH-1:0]   gnt_b;
  logic [2*WIDTH-1:0] mult_p;

  assign s2_load    = !rsp_valid_q || bus.rsp_ready;
  assign s1_adv     = s1_valid_q && s2_load;
  assign can_accept = !s1_valid_q || s2_load;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the lowest
  // set bit of the rotated vector is the offset of the winner from rr_ptr.
  always_comb begin
    rv_dbl  = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    rv_rot  = rv_dbl[NREQ-1:0];
    gnt_any = |rv_rot;
    gnt_off = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rv_rot[k]) begin
        gnt_off = k[IDW-1:0];
      end
    end
    // NREQ need not be a power of two, so wrap explicitly.
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= NREQ_W) begin
      gnt_sum = gnt_sum - NREQ_W;
    end
    gnt_id = gnt_sum[IDW-1:0];
  end

  // rst_n gates the accept so nothing is offered while reset is held.
  always_comb begin
    grant_oh = '0;
    if (gnt_any && can_accept && rst_n) begin
      grant_oh[gnt_id] = 1'b1;
    end
  end

  assign xfer  = |grant_oh;
  assign gnt_a = bus.req_a[gnt_id*WIDTH +: WIDTH];
  assign gnt_b = bus.req_b[gnt_id*WIDTH +: WIDTH];

  array_multiplier #(
    .WIDTH (WIDTH)
  ) u_mult (
    .a (s1_a_q),
    .x (s1_b_q),
    .p (mult_p)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_id_d    = gnt_id;
      s1_a_d     = gnt_a;
      s1_b_d     = gnt_b;
      rr_ptr_d   = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    if (s2_load) begin
      rsp_valid_d = s1_valid_q;
      rsp_id_d    = s1_id_q;
      rsp_prod_d  = mult_p;
    end
  end

  assign ops_done_d = (rsp_valid_q && bus.rsp_ready) ? ops_done_q + 16'd1 : ops_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      rr_ptr_q    <= '0;
      ops_done_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.ops_done  = ops_done_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios, a transaction-level model
// (in-order result queue, round-robin pointer, completion count) compared on
// every cycle, plus literal expectations for the named scenarios.
module tb_mult_share_arbiter;
  localparam int W  = 25;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_share_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) bus ();

  mult_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [2*W-1:0] prod;
  } item_t;

  // Model: results in flight, in order. The front one is on the result
  // channel once m_vis is set; at most one other waits behind it.
  item_t       mq [$];
  bit          m_vis;
  int          m_rr;
  logic [15:0] m_ops;
  logic [N-1:0] last_ready;

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int  pend;
    bit  s1v, s2l, can;
    int  g;
    int  idx;
    r = '0;
    if (!rst_n) return r;
    pend = mq.size() - (m_vis ? 1 : 0);
    s1v  = (pend > 0);
    s2l  = !m_vis || bus.rsp_ready;
    can  = !s1v || s2l;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    if (g >= 0 && can) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0]   rdy;
    logic [2*W-1:0] p;
    item_t          it;
    if (rst_n) begin
      rdy = model_ready();
      if (m_vis && bus.rsp_ready) begin
        void'(mq.pop_front());
        m_vis = 0;
        m_ops = m_ops + 16'd1;
      end
      if (!m_vis && mq.size() > 0) m_vis = 1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          p = {{W{1'b0}}, op_a[i]} * {{W{1'b0}}, op_b[i]};
          it.id = IW'(i);
          it.prod = p;
          mq.push_back(it);
          m_rr = (i + 1) % N;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, compare against the model 1ns later.
  task automatic step(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] er;
    @(negedge clk);
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
    end
    #1;
    er = model_ready();
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_vis));
    if (m_vis && mq.size() > 0) begin
      chk("rsp_id",   64'(bus.rsp_id),   64'(mq[0].id));
      chk("rsp_prod", 64'(bus.rsp_prod), 64'(mq[0].prod));
    end
    chk("ops_done", 64'(bus.ops_done), 64'(m_ops));
    last_ready = bus.req_ready;
  endtask

  task automatic model_clear();
    mq.delete();
    m_vis = 0;
    m_rr  = 0;
    m_ops = '0;
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
    chk({tag, "_rsp_prod"},  64'(bus.rsp_prod),  64'd0);
    chk({tag, "_ops_done"},  64'(bus.ops_done),  64'd0);
  endtask

  logic [N-1:0] grants [8];
  int accepts;
  int n;

  initial begin
    model_clear();
    last_ready = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;

    // Reset state: requests pending but nothing may be accepted.
    #1;
    reset_outputs_zero("reset");
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness with all four requesters valid.
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'(10 + i);
      op_b[i] = W'(100 + 3*i);
    end
    for (int s = 0; s < 8; s++) begin
      step(4'hF, 1'b1);
      grants[s] = last_ready;
      if (s >= 2) begin
        chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rr_rsp_id",    64'(bus.rsp_id),    64'((s - 2) % 4));
      end
    end
    chk("rr_grant0", 64'(grants[0]), 64'h1);
    chk("rr_grant1", 64'(grants[1]), 64'h2);
    chk("rr_grant2", 64'(grants[2]), 64'h4);
    chk("rr_grant3", 64'(grants[3]), 64'h8);
    chk("rr_grant4", 64'(grants[4]), 64'h1);
    chk("rr_grant7", 64'(grants[7]), 64'h8);
    step(4'h0, 1'b1);
    chk("rr_prod_id2", 64'(bus.rsp_prod), 64'(12 * 106));
    step(4'h0, 1'b1);
    step(4'h0, 1'b1);
    chk("rr_drained", 64'(bus.rsp_valid), 64'd0);
    chk("rr_ops", 64'(bus.ops_done), 64'd8);

    // Single request: requester 2, 3*7.
    op_a[2] = W'(3);
    op_b[2] = W'(7);
    step(4'b0100, 1'b1);
    chk("single_ready", 64'(last_ready), 64'b0100);
    step(4'b0000, 1'b1);
    chk("single_not_yet", 64'(bus.rsp_valid), 64'd0);
    step(4'b0000, 1'b1);
    chk("single_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_id",    64'(bus.rsp_id),    64'd2);
    chk("single_prod",  64'(bus.rsp_prod),  64'd21);
    step(4'b0000, 1'b1);
    chk("single_ops",   64'(bus.ops_done),  64'd9);
    chk("single_idle",  64'(bus.rsp_valid), 64'd0);

    // Backpressure: requester 0 streams while the consumer stalls 5 cycles.
    op_a[0] = W'(11);
    op_b[0] = W'(13);
    accepts = 0;
    for (int s = 0; s < 5; s++) begin
      step(4'b0001, 1'b0);
      accepts += int'(last_ready[0]);
    end
    chk("bp_accepts",   64'(accepts),       64'd2);
    chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    chk("bp_hold_prod", 64'(bus.rsp_prod),  64'd143);
    step(4'b0001, 1'b1);
    chk("bp_release_accept", 64'(last_ready), 64'b0001);
    for (int s = 0; s < 4; s++) step(4'b0000, 1'b1);
    chk("bp_ops", 64'(bus.ops_done), 64'd12);

    // Extremes.
    op_a[1] = 25'h1FFFFFF;
    op_b[1] = 25'h1FFFFFF;
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("max_valid", 64'(bus.rsp_valid), 64'd1);
    chk("max_prod",  64'(bus.rsp_prod),  64'h3FFFFFC000001);
    op_a[0] = 25'h0;
    op_b[0] = 25'h1FFFFFF;
    op_a[3] = 25'h1;
    op_b[3] = 25'h5;
    step(4'b1001, 1'b1);
    chk("ext_grant3", 64'(last_ready), 64'b1000);
    step(4'b0001, 1'b1);
    chk("ext_grant0", 64'(last_ready), 64'b0001);
    step(4'b0000, 1'b1);
    chk("one_id",   64'(bus.rsp_id),   64'd3);
    chk("one_prod", 64'(bus.rsp_prod), 64'd5);
    step(4'b0000, 1'b1);
    chk("zero_id",    64'(bus.rsp_id),    64'd0);
    chk("zero_valid", 64'(bus.rsp_valid), 64'd1);
    chk("zero_prod",  64'(bus.rsp_prod),  64'd0);
    step(4'b0000, 1'b1);

    // Reset with S1 and S2 both full.
    op_a[2] = W'(9);
    op_b[2] = W'(9);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("mid_full_valid", 64'(bus.rsp_valid), 64'd1);
    chk("mid_full_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    reset_outputs_zero("midrst");
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op_a[3] = W'(6);
    op_b[3] = W'(7);
    step(4'b1000, 1'b1);
    chk("post_rst_ready", 64'(last_ready), 64'b1000);
    step(4'b0000, 1'b1);
    chk("post_rst_nostale", 64'(bus.rsp_valid), 64'd0);
    step(4'b0000, 1'b1);
    chk("post_rst_valid", 64'(bus.rsp_valid), 64'd1);
    chk("post_rst_id",    64'(bus.rsp_id),    64'd3);
    chk("post_rst_prod",  64'(bus.rsp_prod),  64'd42);
    step(4'b0000, 1'b1);
    chk("post_rst_once", 64'(bus.rsp_valid), 64'd0);
    chk("post_rst_ops",  64'(bus.ops_done),  64'd1);

    // Counter wrap through a long back-to-back stream.
    op_a[0] = W'(2);
    op_b[0] = W'(3);
    n = 0;
    while (m_ops != 16'hFFFF && n < 70000) begin
      step(4'b0001, 1'b1);
      n++;
    end
    chk("wrap_reached", 64'(n < 70000), 64'd1);
    chk("wrap_ffff", 64'(bus.ops_done), 64'hFFFF);
    step(4'b0001, 1'b1);
    chk("wrap_zero", 64'(bus.ops_done), 64'd0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("wrap_drained", 64'(bus.rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
